sprite_rom_arbiter: RTL and testbench

Shares one synchronous single-port sprite ROM (1-cycle read latency, palette-index output) among several pixel requesters, e.g. display path, tank 1, tank 2 and projectile sprite fetchers. Each cycle it grants at most one requester, drives the ROM address, and returns the ROM data to the granted requester with an ID tag. It sits between the sprite-drawing logic and the sprite ROM/palette pair, in the vga_clk domain.

---
 rtl/sprite_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM among NUM_REQ pixel requesters.
// Optional build macro DISPLAY_PRIORITY_EN gives requester 0 fixed absolute priority.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 2
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

`ifdef DISPLAY_PRIORITY_EN
    localparam logic [ID_W-1:0] RR_RESET = ID_W'(1);
    localparam logic [ID_W-1:0] RR_WRAP  = ID_W'(1);
`else
    localparam logic [ID_W-1:0] RR_RESET = '0;
    localparam logic [ID_W-1:0] RR_WRAP  = '0;
`endif
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              p1_valid_q, p1_valid_d;
    logic [ID_W-1:0]   p1_id_q, p1_id_d;
    logic              p2_valid_q, p2_valid_d;
    logic [ID_W-1:0]   p2_id_q, p2_id_d;

    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   scan_id;

    // Scan upward from rr_q with explicit wrap so non-power-of-2 NUM_REQ never visits a phantom slot.
    always_comb begin
        gnt         = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_id     = rr_q;
        if (reset_n) begin
`ifdef DISPLAY_PRIORITY_EN
            if (req[0]) begin
                grant_valid = 1'b1;
                grant_id    = '0;
            end else begin
                for (int k = 0; k < NUM_REQ - 1; k++) begin
                    if (!grant_valid && req[scan_id]) begin
                        grant_valid = 1'b1;
                        grant_id    = scan_id;
                    end
                    scan_id = (scan_id == LAST_ID) ? RR_WRAP : scan_id + ID_W'(1);
                end
            end
`else
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_valid && req[scan_id]) begin
                    grant_valid = 1'b1;
                    grant_id    = scan_id;
                end
                scan_id = (scan_id == LAST_ID) ? RR_WRAP : scan_id + ID_W'(1);
            end
`endif
            if (grant_valid) begin
                gnt[grant_id] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d          = rr_q;
        rom_address_d = rom_address_q;
        p1_valid_d    = grant_valid;
        p1_id_d       = p1_id_q;
        p2_valid_d    = p1_valid_q;
        p2_id_d       = p1_id_q;
        if (grant_valid) begin
            rom_address_d = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
            p1_id_d       = grant_id;
`ifdef DISPLAY_PRIORITY_EN
            // The display path never moves the pointer, so it stays within 1..NUM_REQ-1.
            if (grant_id != '0) begin
                rr_d = (grant_id == LAST_ID) ? RR_WRAP : grant_id + ID_W'(1);
            end
`else
            rr_d = (grant_id == LAST_ID) ? RR_WRAP : grant_id + ID_W'(1);
`endif
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rr_q          <= RR_RESET;
            rom_address_q <= '0;
            p1_valid_q    <= 1'b0;
            p1_id_q       <= '0;
            p2_valid_q    <= 1'b0;
            p2_id_q       <= '0;
        end else begin
            rr_q          <= rr_d;
            rom_address_q <= rom_address_d;
            p1_valid_q    <= p1_valid_d;
            p1_id_q       <= p1_id_d;
            p2_valid_q    <= p2_valid_d;
            p2_id_q       <= p2_id_d;
        end
    end

    assign rom_address = rom_address_q;
    assign rsp_valid   = p2_valid_q;
    assign rsp_id      = p2_id_q;
    assign rsp_data    = p2_valid_q ? rom_q : '0;
    assign busy        = p1_valid_q | p2_valid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table, reset corner cases and
// randomized traffic checked against a queue-based reference model.
module tb_sprite_rom_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 4;
    localparam int IW = 2;

`ifdef DISPLAY_PRIORITY_EN
    localparam int PTR_RST = 1;
`else
    localparam int PTR_RST = 0;
`endif

    logic             vga_clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    gnt;
    logic [AW-1:0]    rom_address;
    logic [DW-1:0]    rom_q;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             busy;

    sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    // Sprite ROM: one-cycle synchronous read.
    logic [DW-1:0] rom_mem [1024];
    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    typedef struct {
        int          due;
        int          id;
        logic [AW-1:0] addr;
    } pend_t;

    typedef struct {
        logic          rst_n;
        logic [NR-1:0] rq;
        logic [NR-1:0] exp_gnt;
        logic          chk;
        logic          exp_rv;
        logic [IW-1:0] exp_id;
    } vec_t;

    pend_t pend[$];
    vec_t  vecs[$];
    int    ptr;
    int    cyc;
    bit    known;
    logic [AW-1:0]    exp_addr;
    logic             cur_rst;
    logic [NR-1:0]    cur_req;
    logic [NR*AW-1:0] cur_addr;
    int total;
    int bad;

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pickWinner(input logic [NR-1:0] r);
`ifdef DISPLAY_PRIORITY_EN
        if (r[0]) return 0;
        for (int k = 0; k < NR - 1; k++) begin
            int id = 1 + ((ptr - 1 + k) % (NR - 1));
            if (r[id]) return id;
        end
`else
        for (int k = 0; k < NR; k++) begin
            int id = (ptr + k) % NR;
            if (r[id]) return id;
        end
`endif
        return -1;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [NR-1:0] r, input logic [NR*AW-1:0] a);
        @(negedge vga_clk);
        reset_n  = rst;
        req      = r;
        req_addr = a;
        cur_rst  = rst;
        cur_req  = r;
        cur_addr = a;
        #1;
    endtask

    task automatic checkOutput();
        int w;
        bit ev;
        w = cur_rst ? pickWinner(cur_req) : -1;
        checkOne("gnt", 32'(gnt), (w >= 0) ? (32'd1 << w) : 32'd0);
        if (known) begin
            ev = (pend.size() > 0) && (pend[0].due == cyc);
            checkOne("rsp_valid", 32'(rsp_valid), 32'(ev));
            checkOne("busy", 32'(busy), 32'(pend.size() > 0));
            checkOne("rom_address", 32'(rom_address), 32'(exp_addr));
            if (ev) begin
                checkOne("rsp_id", 32'(rsp_id), 32'(pend[0].id));
                checkOne("rsp_data", 32'(rsp_data), 32'(rom_mem[pend[0].addr]));
            end else begin
                checkOne("rsp_data_idle", 32'(rsp_data), 32'd0);
            end
        end
    endtask

    task automatic advanceModel();
        int w;
        w = cur_rst ? pickWinner(cur_req) : -1;
        @(posedge vga_clk);
        if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
        if (!cur_rst) begin
            pend.delete();
            ptr      = PTR_RST;
            exp_addr = '0;
            known    = 1'b1;
        end else if (w >= 0) begin
            pend.push_back('{cyc + 2, w, cur_addr[w*AW +: AW]});
            exp_addr = cur_addr[w*AW +: AW];
`ifdef DISPLAY_PRIORITY_EN
            if (w != 0) ptr = 1 + (w % (NR - 1));
`else
            ptr = (w + 1) % NR;
`endif
        end
        cyc++;
    endtask

    task automatic stepCycle(input logic rst, input logic [NR-1:0] r, input logic [NR*AW-1:0] a);
        applyStimulus(rst, r, a);
        checkOutput();
        advanceModel();
    endtask

    localparam logic [NR*AW-1:0] TBL_ADDR = {10'h2A5, 10'h15A, 10'h0F0, 10'h3C3};

    initial begin
        logic [63:0] rnd;
        total = 0;
        bad   = 0;
        ptr   = PTR_RST;
        cyc   = 0;
        known = 1'b0;
        exp_addr = '0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = DW'($urandom);

`ifndef DISPLAY_PRIORITY_EN
        vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b0010, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b0100, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b1000, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{1'b1, 4'b1111, 4'b0001, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 4'b1111, 4'b0010, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{1'b1, 4'b1111, 4'b0100, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b1, 4'b1111, 4'b1000, 1'b1, 1'b1, 2'd1});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd3});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 4'b0101, 4'b0100, 1'b1, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].rq, TBL_ADDR);
            checkOutput();
            checkOne($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            if (vecs[i].chk) begin
                checkOne($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rv));
                if (vecs[i].exp_rv) checkOne($sformatf("vec%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].exp_id));
            end
            if (i == 15) checkOne("single_read_rom_address", 32'(rom_address), 32'h15A);
            if (i == 15) checkOne("single_read_busy", 32'(busy), 32'd1);
            advanceModel();
        end

        // Reset lands while a read sits in p1; it must never surface as a response.
        stepCycle(1'b1, 4'b0010, TBL_ADDR);
        stepCycle(1'b0, 4'b0000, TBL_ADDR);
        applyStimulus(1'b1, 4'b0000, TBL_ADDR);
        checkOutput();
        checkOne("midflight_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOne("midflight_rsp_id", 32'(rsp_id), 32'd0);
        checkOne("midflight_busy", 32'(busy), 32'd0);
        advanceModel();
        applyStimulus(1'b1, 4'b1111, TBL_ADDR);
        checkOutput();
        checkOne("midflight_ptr_restart", 32'(gnt), 32'b0001);
        advanceModel();
`else
        stepCycle(1'b0, 4'b1111, TBL_ADDR);
        stepCycle(1'b0, 4'b1111, TBL_ADDR);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b1111, TBL_ADDR);
            checkOutput();
            checkOne($sformatf("prio_disp%0d", i), 32'(gnt), 32'b0001);
            advanceModel();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b1110, TBL_ADDR);
            checkOutput();
            checkOne($sformatf("prio_rr%0d", i), 32'(gnt), 32'd1 << (i + 1));
            advanceModel();
        end
        applyStimulus(1'b1, 4'b1111, TBL_ADDR);
        checkOutput();
        checkOne("prio_disp_again", 32'(gnt), 32'b0001);
        advanceModel();
`endif

        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom};
            stepCycle(($urandom_range(0, 39) != 0), NR'($urandom_range(0, 15)), rnd[NR*AW-1:0]);
        end
        stepCycle(1'b1, 4'b0000, TBL_ADDR);
        stepCycle(1'b1, 4'b0000, TBL_ADDR);
        stepCycle(1'b1, 4'b0000, TBL_ADDR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
